pc_redirect_ctrl: RTL and testbench
===================================

Name: pc_redirect_ctrl

Overview:
- Sequencing controller for the instruction-fetch PC register.
- Collects redirect requests from decode (jump, jump-register, taken branch), from the branch-resolution stage (mispredict) and from CP0 (interrupt entry, exception return).
- Priority-arbitrates them, holds a redirect pending while EX stalls, and drives the fetch unit's PC-source select and PC write enable.
- Generates pipeline flushes and a multi-cycle interrupt drain, and counts applied redirects for performance monitoring.

Parameters:
- DRAIN_CYCLES, 2, cycles of flush held after interrupt entry (range 1-15).
- CNT_W, 16, width of the applied-redirect performance counter.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous active-low reset.
- ex_stall  in  1  EX stage stall; PC must not be written while high.
- irq_req  in  1  CP0 interrupt/exception entry request (level, held until irq_sel seen).
- eret_req  in  1  return-from-interrupt request.
- mispredict  in  1  branch resolved against prediction; refetch from ID next-PC.
- jr_req  in  1  JR/JALR decoded.
- jmp_req  in  1  J/JAL decoded.
- br_taken  in  1  conditional branch decoded and taken.
- pc_sel  out  2  fetch PC source: 00 PC+4, 01 branch target, 10 jump target, 11 register/EPC target.
- wpc  out  1  PC write enable to fetch unit.
- irq_sel  out  1  select interrupt vector (overrides pc_sel).
- mis_sel  out  1  select ID next-PC (overrides pc_sel, below irq_sel).
- eret_sel  out  1  register target comes from EPC (valid with pc_sel=11).
- if_flush  out  1  squash IF/ID register.
- id_flush  out  1  squash ID/EX register.
- pending  out  1  redirect latched, waiting for stall release.
- redirect_cnt  out  CNT_W  count of applied non-sequential redirects, saturating.

Behaviour:
- Request kinds, priority high to low: IRQ > MIS > ERET > JR > JMP > BR > SEQ. The winner is the highest asserted request. Kinds are encoded internally in 3 bits.
- FSM states: RUN, HOLD, DRAIN. Reset (asynchronous, reset=0) forces:
  - state=RUN, latched kind=SEQ, drain counter=0, redirect_cnt=0.
  - All outputs 0, except wpc follows the RUN equations once reset releases.
- Outputs are combinational from state, latched kind and current requests. State, latched kind, counter and redirect_cnt are registered.
- Applying kind K (same cycle):
  - wpc=1.
  - IRQ: irq_sel=1.
  - MIS: mis_sel=1.
  - ERET: pc_sel=11, eret_sel=1.
  - JR: pc_sel=11.
  - JMP: pc_sel=10.
  - BR: pc_sel=01.
  - SEQ: pc_sel=00.
  - if_flush=1 for every K except SEQ. id_flush=1 for IRQ, MIS, ERET.
  - redirect_cnt increments on every applied K except SEQ, saturating at all-ones.
- RUN:
  - ex_stall=0: apply winner. If winner=IRQ, go to DRAIN with counter=DRAIN_CYCLES-1. Otherwise stay in RUN.
  - ex_stall=1: wpc=0, no flush. If winner is not SEQ, latch it and go to HOLD.
- HOLD:
  - pending=1.
  - Each cycle, a newly asserted request of strictly higher priority replaces the latched kind. Equal or lower priority requests are dropped.
  - While ex_stall=1: wpc=0, no flush.
  - On the first cycle with ex_stall=0: apply max(latched, current winner), clear the latch, and go to DRAIN if the applied kind is IRQ, else RUN.
- DRAIN:
  - wpc=0, if_flush=1, id_flush=1. All requests are ignored; irq_req stays masked.
  - Counter decrements each cycle. When counter=0 in DRAIN, the next state is RUN.
  - With DRAIN_CYCLES=1, DRAIN lasts exactly 1 cycle.
  - ex_stall has no effect in DRAIN.
- Simultaneous events:
  - mispredict with jmp_req in the same cycle: MIS wins and the jump is dropped, because the decode slot is squashed.
  - irq_req with any other request: IRQ wins.
- Reset asserted mid-HOLD or mid-DRAIN discards the latched redirect and the remaining drain immediately (asynchronously).
- Latency: a redirect is applied in the request cycle when unstalled, otherwise in the first unstalled cycle. There is never a lost redirect of the highest priority.

Test Plan:
- Reset release, no requests, ex_stall=0 for 5 cycles -> wpc=1, pc_sel=00, flushes 0, redirect_cnt=0.
- jmp_req pulse, ex_stall=0 -> same cycle: pc_sel=10, wpc=1, if_flush=1, id_flush=0; redirect_cnt=1 next cycle.
- br_taken with ex_stall=1 for 3 cycles, jr_req raised in the 2nd stalled cycle, stall drops -> pending=1 for 3 cycles, wpc=0. On release: pc_sel=11, wpc=1, if_flush=1, pending=0, redirect_cnt +1 (the branch is dropped).
- irq_req with jmp_req, ex_stall=0, DRAIN_CYCLES=2 -> cycle 0: irq_sel=1, wpc=1, both flushes. Cycles 1-2: wpc=0, both flushes, jmp_req ignored. Cycle 3: back to RUN, wpc=1.
- mispredict and jmp_req together -> mis_sel=1, pc_sel not 10, id_flush=1, if_flush=1.
- reset pulled low during DRAIN and during HOLD -> outputs immediately 0, pending=0. After release: RUN, redirect_cnt=0. Separately, force 2^CNT_W+3 jumps -> redirect_cnt holds at all-ones.

Source files
------------

// File: rtl/pc_redirect_ctrl.sv
// Fetch-PC redirect sequencer: arbitrates decode/resolve/CP0 redirects, holds them
// across EX stalls, drives PC source/write enable, flushes and a redirect counter.
module pc_redirect_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ex_stall,
  input  logic             irq_req,
  input  logic             eret_req,
  input  logic             mispredict,
  input  logic             jr_req,
  input  logic             jmp_req,
  input  logic             br_taken,
  output logic [1:0]       pc_sel,
  output logic             wpc,
  output logic             irq_sel,
  output logic             mis_sel,
  output logic             eret_sel,
  output logic             if_flush,
  output logic             id_flush,
  output logic             pending,
  output logic [CNT_W-1:0] redirect_cnt
);

  // Numeric order doubles as priority, so "higher priority" is a plain compare.
  typedef enum logic [2:0] {
    K_SEQ  = 3'd0,
    K_BR   = 3'd1,
    K_JMP  = 3'd2,
    K_JR   = 3'd3,
    K_ERET = 3'd4,
    K_MIS  = 3'd5,
    K_IRQ  = 3'd6
  } kind_e;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES - 1);

  state_e           state_q, state_d;
  kind_e            kind_q, kind_d;
  kind_e            win_s, apply_kind_s;
  logic [3:0]       dcnt_q, dcnt_d;
  logic [CNT_W-1:0] cnt_q;
  logic             apply_s, pend_s, drain_s;
  logic [1:0]       pc_sel_s;
  logic             wpc_s, irq_sel_s, mis_sel_s, eret_sel_s, if_flush_s, id_flush_s;

  always_comb begin
    win_s = K_SEQ;
    if (irq_req)         win_s = K_IRQ;
    else if (mispredict) win_s = K_MIS;
    else if (eret_req)   win_s = K_ERET;
    else if (jr_req)     win_s = K_JR;
    else if (jmp_req)    win_s = K_JMP;
    else if (br_taken)   win_s = K_BR;
    else                 win_s = K_SEQ;
  end

  always_comb begin
    state_d      = state_q;
    kind_d       = kind_q;
    dcnt_d       = dcnt_q;
    apply_s      = 1'b0;
    apply_kind_s = K_SEQ;
    pend_s       = 1'b0;
    drain_s      = 1'b0;
    case (state_q)
      S_RUN: begin
        if (!ex_stall) begin
          apply_s      = 1'b1;
          apply_kind_s = win_s;
          if (win_s == K_IRQ) begin
            state_d = S_DRAIN;
            dcnt_d  = DRAIN_INIT;
          end
        end else if (win_s != K_SEQ) begin
          pend_s  = 1'b1;
          kind_d  = win_s;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (ex_stall) begin
          pend_s = 1'b1;
          if (win_s > kind_q) kind_d = win_s;
        end else begin
          apply_s = 1'b1;
          if (win_s > kind_q) apply_kind_s = win_s;
          else                apply_kind_s = kind_q;
          kind_d = K_SEQ;
          if (apply_kind_s == K_IRQ) begin
            state_d = S_DRAIN;
            dcnt_d  = DRAIN_INIT;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_DRAIN: begin
        drain_s = 1'b1;
        if (dcnt_q == 4'd0) state_d = S_RUN;
        else                dcnt_d  = dcnt_q - 4'd1;
      end
      default: begin
        state_d = S_RUN;
        kind_d  = K_SEQ;
        dcnt_d  = 4'd0;
      end
    endcase
  end

  always_comb begin
    pc_sel_s   = 2'b00;
    wpc_s      = 1'b0;
    irq_sel_s  = 1'b0;
    mis_sel_s  = 1'b0;
    eret_sel_s = 1'b0;
    if_flush_s = 1'b0;
    id_flush_s = 1'b0;
    if (apply_s) begin
      wpc_s      = 1'b1;
      if_flush_s = (apply_kind_s != K_SEQ);
      id_flush_s = (apply_kind_s >= K_ERET);
      case (apply_kind_s)
        K_IRQ:   irq_sel_s = 1'b1;
        K_MIS:   mis_sel_s = 1'b1;
        K_ERET:  begin pc_sel_s = 2'b11; eret_sel_s = 1'b1; end
        K_JR:    pc_sel_s = 2'b11;
        K_JMP:   pc_sel_s = 2'b10;
        K_BR:    pc_sel_s = 2'b01;
        default: pc_sel_s = 2'b00;
      endcase
    end else if (drain_s) begin
      if_flush_s = 1'b1;
      id_flush_s = 1'b1;
    end else begin
      wpc_s = 1'b0;
    end
  end

  // Outputs are forced low for the whole time reset is held, not just at the edge.
  assign pc_sel       = reset ? pc_sel_s   : 2'b00;
  assign wpc          = reset ? wpc_s      : 1'b0;
  assign irq_sel      = reset ? irq_sel_s  : 1'b0;
  assign mis_sel      = reset ? mis_sel_s  : 1'b0;
  assign eret_sel     = reset ? eret_sel_s : 1'b0;
  assign if_flush     = reset ? if_flush_s : 1'b0;
  assign id_flush     = reset ? id_flush_s : 1'b0;
  assign pending      = reset ? pend_s     : 1'b0;
  assign redirect_cnt = cnt_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_RUN;
      kind_q  <= K_SEQ;
      dcnt_q  <= 4'd0;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      dcnt_q  <= dcnt_d;
      if (apply_s && (apply_kind_s != K_SEQ) && (cnt_q != {CNT_W{1'b1}}))
        cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed vector bench for pc_redirect_ctrl: a table of per-cycle requests and
// expected outputs, plus reset-abort and counter saturation sequences.
module tb_pc_redirect_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ex_stall = 1'b0, irq_req = 1'b0, eret_req = 1'b0, mispredict = 1'b0;
  logic        jr_req = 1'b0, jmp_req = 1'b0, br_taken = 1'b0;
  logic [1:0]  pc_sel;
  logic        wpc, irq_sel, mis_sel, eret_sel, if_flush, id_flush, pending;
  logic [15:0] redirect_cnt;

  int n_pass = 0;
  int n_total = 0;

  // req = {stall,irq,eret,mis,jr,jmp,br}; outs = {pc_sel[1:0],wpc,irq_sel,mis_sel,eret_sel,if,id,pend}
  typedef struct {
    logic [6:0]  req;
    logic [8:0]  outs;
    logic [15:0] cnt;
    string       name;
  } vec_t;

  vec_t vecs[$];

  pc_redirect_ctrl #(.DRAIN_CYCLES(2), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .ex_stall(ex_stall), .irq_req(irq_req),
    .eret_req(eret_req), .mispredict(mispredict), .jr_req(jr_req),
    .jmp_req(jmp_req), .br_taken(br_taken), .pc_sel(pc_sel), .wpc(wpc),
    .irq_sel(irq_sel), .mis_sel(mis_sel), .eret_sel(eret_sel),
    .if_flush(if_flush), .id_flush(id_flush), .pending(pending),
    .redirect_cnt(redirect_cnt)
  );

  always #5 clock = ~clock;

  function automatic logic [8:0] outs_now();
    return {pc_sel, wpc, irq_sel, mis_sel, eret_sel, if_flush, id_flush, pending};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drive(input logic [6:0] r);
    {ex_stall, irq_req, eret_req, mispredict, jr_req, jmp_req, br_taken} = r;
  endtask

  initial begin
    vecs.push_back('{7'b0000000, 9'b001000000, 16'd0, "idle0"});
    vecs.push_back('{7'b0000000, 9'b001000000, 16'd0, "idle1"});
    vecs.push_back('{7'b0000000, 9'b001000000, 16'd0, "idle2"});
    vecs.push_back('{7'b0000000, 9'b001000000, 16'd0, "idle3"});
    vecs.push_back('{7'b0000000, 9'b001000000, 16'd0, "idle4"});
    vecs.push_back('{7'b0000010, 9'b101000100, 16'd0, "jmp"});
    vecs.push_back('{7'b0000000, 9'b001000000, 16'd1, "after_jmp"});
    vecs.push_back('{7'b1000001, 9'b000000001, 16'd1, "stall_br"});
    vecs.push_back('{7'b1000101, 9'b000000001, 16'd1, "stall_br_jr"});
    vecs.push_back('{7'b1000001, 9'b000000001, 16'd1, "stall_br2"});
    vecs.push_back('{7'b0000000, 9'b111000100, 16'd1, "release_jr"});
    vecs.push_back('{7'b0000000, 9'b001000000, 16'd2, "after_jr"});
    vecs.push_back('{7'b0100010, 9'b001100110, 16'd2, "irq_jmp"});
    vecs.push_back('{7'b0000010, 9'b000000110, 16'd3, "drain1_jmp"});
    vecs.push_back('{7'b1000010, 9'b000000110, 16'd3, "drain2_stall"});
    vecs.push_back('{7'b0000000, 9'b001000000, 16'd3, "back_run"});
    vecs.push_back('{7'b0001010, 9'b001010110, 16'd3, "mis_jmp"});
    vecs.push_back('{7'b0010000, 9'b111001110, 16'd4, "eret"});
    vecs.push_back('{7'b0000001, 9'b011000100, 16'd5, "br"});
    vecs.push_back('{7'b0000101, 9'b111000100, 16'd6, "jr_br"});
    vecs.push_back('{7'b1000010, 9'b000000001, 16'd7, "stall_jmp"});
    vecs.push_back('{7'b1000001, 9'b000000001, 16'd7, "stall_lower_br"});
    vecs.push_back('{7'b0000001, 9'b101000100, 16'd7, "release_max_jmp"});
    vecs.push_back('{7'b0000000, 9'b001000000, 16'd8, "after_rel"});
    vecs.push_back('{7'b1100000, 9'b000000001, 16'd8, "stall_irq"});
    vecs.push_back('{7'b0100000, 9'b001100110, 16'd8, "release_irq"});
    vecs.push_back('{7'b0000000, 9'b000000110, 16'd9, "hdrain1"});
    vecs.push_back('{7'b0000000, 9'b000000110, 16'd9, "hdrain2"});
    vecs.push_back('{7'b0000000, 9'b001000000, 16'd9, "hrun"});

    // Reset held with no requests and no stall: outputs must stay 0.
    #3;
    chk("reset_outs", {23'd0, outs_now()}, 32'd0);
    chk("reset_cnt", {16'd0, redirect_cnt}, 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;

    foreach (vecs[i]) begin
      if (i != 0) @(negedge clock);
      drive(vecs[i].req);
      #2;
      chk({vecs[i].name, "_outs"}, {23'd0, outs_now()}, {23'd0, vecs[i].outs});
      chk({vecs[i].name, "_cnt"}, {16'd0, redirect_cnt}, {16'd0, vecs[i].cnt});
    end

    // Reset asserted while a jump is held pending.
    @(negedge clock);
    drive(7'b1000010);
    @(posedge clock);
    #2;
    chk("hold_pending", {31'd0, pending}, 32'd1);
    reset = 1'b0;
    #1;
    chk("hold_rst_outs", {23'd0, outs_now()}, 32'd0);
    chk("hold_rst_cnt", {16'd0, redirect_cnt}, 32'd0);
    drive(7'b0000000);
    @(negedge clock);
    reset = 1'b1;
    #2;
    chk("hold_rel_outs", {23'd0, outs_now()}, {23'd0, 9'b001000000});

    // Reset asserted mid-drain.
    @(negedge clock);
    drive(7'b0100000);
    #2;
    chk("irq_apply", {23'd0, outs_now()}, {23'd0, 9'b001100110});
    @(posedge clock);
    #2;
    drive(7'b0000000);
    #1;
    chk("drain_outs", {23'd0, outs_now()}, {23'd0, 9'b000000110});
    reset = 1'b0;
    #1;
    chk("drain_rst_outs", {23'd0, outs_now()}, 32'd0);
    chk("drain_rst_cnt", {16'd0, redirect_cnt}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    #2;
    chk("drain_rel_outs", {23'd0, outs_now()}, {23'd0, 9'b001000000});

    // Counter saturation: 2^16+3 back-to-back jumps.
    @(negedge clock);
    drive(7'b0000010);
    repeat (65534) @(negedge clock);
    #1;
    chk("cnt_near_sat", {16'd0, redirect_cnt}, {16'd0, 16'hFFFE});
    repeat (5) @(negedge clock);
    drive(7'b0000000);
    #1;
    chk("cnt_sat", {16'd0, redirect_cnt}, {16'd0, 16'hFFFF});
    @(negedge clock);
    #1;
    chk("cnt_sat_hold", {16'd0, redirect_cnt}, {16'd0, 16'hFFFF});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
